reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Read-after-write hazard scheduler for the 32-entry integer register file.
- Tracks in-flight writes per destination register: +1 on accepted issue from ID, -1 on writeback from MEM/WB.
- Asserts `stall` to ID while a source operand's producer has not yet reached WB.
- Honours the register file's same-cycle WB->ID forwarding, so a write retiring this cycle does not stall.

Parameters:
- REG_NUM, 32, number of architectural registers; entry 0 is hardwired zero.
- ADDR_W, 5, register address width.
- CNT_W, 2, per-register pending counter width; max in-flight writes per register = 2^CNT_W-1.
- TOT_W, 7, width of the total in-flight counter; must be >= ADDR_W+CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  clear all pending state (pipeline squash, issued only once younger ops are killed)
- issue_valid  in  1  ID presents an instruction
- issue_we  in  1  instruction writes rd
- issue_rd  in  ADDR_W  destination register
- issue_re1  in  1  rs1 is read
- issue_rs1  in  ADDR_W  source 1
- issue_re2  in  1  rs2 is read
- issue_rs2  in  ADDR_W  source 2
- wb_we  in  1  writeback enable (same signal driving the register file write port)
- wb_addr  in  ADDR_W  writeback address
- stall  out  1  ID must hold; the instruction is not accepted
- busy_vec  out  REG_NUM  bit i = pending count of register i is nonzero
- pending_total  out  TOT_W  sum of all pending counts
- err_underflow  out  1  sticky: a writeback arrived with no pending entry

Behaviour:
- **State:** cnt[i] (CNT_W bits, i=1..REG_NUM-1), pending_total, err_underflow. cnt[0] is constant 0.
- **Reset:** on a clk edge with rst=1, all cnt=0, pending_total=0, err_underflow=0. Consequently busy_vec=0 and stall=0 (stall is combinational on zero state). rst has priority over flush, issue and wb.
- **WB retiring on a source:** wb_ret(r) = wb_we && wb_addr==r && r!=0.
- **Source hazard:** hz(r, re) = re && r!=0 && cnt[r]!=0 && !(cnt[r]==1 && wb_ret(r)).
- **Overflow hazard:** ov = issue_we && issue_rd!=0 && cnt[issue_rd]==max && !wb_ret(issue_rd).
- **Stall:** stall = issue_valid && !flush && (hz(rs1,re1) || hz(rs2,re2) || ov). Purely combinational; zero-cycle latency to ID.
- **Accept:** acc = issue_valid && !stall && !flush. inc = acc && issue_we && issue_rd!=0.
- **Decrement:** dec = wb_we && wb_addr!=0 && cnt[wb_addr]!=0.
- **Underflow:** wb_we && wb_addr!=0 && cnt[wb_addr]==0 sets err_underflow (sticky until rst). The count stays 0; pending_total is unchanged.
- **Counter update (next clk edge):**
  - cnt[issue_rd] += inc.
  - cnt[wb_addr] -= dec.
  - Same register with inc and dec together: count unchanged.
  - pending_total += inc - dec.
- **Zero register:** writes to x0 are never tracked; reads of x0 never stall.
- **Self-dependence:** issue with rd==rs1 and that register pending stalls on rs1. Once accepted, the new write is counted.
- **Flush:**
  - All cnt and pending_total go to 0 at the next edge.
  - In the flush cycle, issue is ignored and stall=0.
  - A wb in the flush cycle is discarded without raising err_underflow.
  - Writebacks after the flush that find cnt==0 do raise err_underflow; the controller guarantees the pipeline is drained past WB before asserting flush.
- **No saturation paths:** inc cannot exceed max because ov stalls. pending_total cannot exceed (REG_NUM-1)*max, which fits in TOT_W.

Test Plan:
- **Reset:** rst=1 for 2 cycles with issue_valid=1, issue_we=1, rd=5 -> after release busy_vec=0, pending_total=0, stall=0, err_underflow=0.
- **RAW stall and release:**
  - Issue we rd=3 (accepted, cnt[3]=1, busy_vec=0x8).
  - Next cycle issue re1 rs1=3 -> stall=1 and holds while wb_we=0.
  - Cycle with wb_we=1, wb_addr=3 -> stall=0 in that same cycle, instruction accepted, next cycle busy_vec=0.
- **Overflow:**
  - Issue rd=7 three times with no wb -> cnt[7]=3, pending_total=3.
  - 4th issue rd=7 -> stall=1.
  - Same 4th issue with wb_we=1, wb_addr=7 -> stall=0, cnt[7] stays 3.
- **x0 and simultaneous events:**
  - Issue rd=0, rs1=0 -> never stalls, pending_total unchanged.
  - Issue rd=9 with wb_addr=9 while cnt[9]=1 -> cnt[9]=1 afterwards.
- **Underflow and flush:**
  - wb_we=1, wb_addr=12 with cnt[12]=0 -> err_underflow=1 and stays 1.
  - With cnt[4]=2, cnt[8]=1, assert flush with issue_valid=1, rs1=4 -> stall=0, next cycle busy_vec=0, pending_total=0.
- **Reset mid-operation:** with pending_total=5, rst=1 for one cycle -> all state 0, err_underflow cleared.

Source files
------------

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - read-after-write hazard scoreboard for the integer register file
module reg_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int TOT_W   = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               issue_valid,
    input  logic               issue_we,
    input  logic [ADDR_W-1:0]  issue_rd,
    input  logic               issue_re1,
    input  logic [ADDR_W-1:0]  issue_rs1,
    input  logic               issue_re2,
    input  logic [ADDR_W-1:0]  issue_rs2,
    input  logic               wb_we,
    input  logic [ADDR_W-1:0]  wb_addr,
    output logic               stall,
    output logic [REG_NUM-1:0] busy_vec,
    output logic [TOT_W-1:0]   pending_total,
    output logic               err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [REG_NUM];
    logic [CNT_W-1:0] cnt_d [REG_NUM];
    logic [TOT_W-1:0] total_q, total_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             wb_nz, wb_ret1, wb_ret2, wb_retd;
    logic             hz1, hz2, ov;
    logic             acc, inc, dec, underflow;

    // A write retiring this cycle is forwarded by the register file, so it hides its own hazard.
    always_comb begin
        cnt_rs1 = cnt_q[issue_rs1];
        cnt_rs2 = cnt_q[issue_rs2];
        cnt_rd  = cnt_q[issue_rd];
        cnt_wb  = cnt_q[wb_addr];
        wb_nz   = wb_we && (wb_addr != '0);
        wb_ret1 = wb_nz && (wb_addr == issue_rs1);
        wb_ret2 = wb_nz && (wb_addr == issue_rs2);
        wb_retd = wb_nz && (wb_addr == issue_rd);

        hz1 = issue_re1 && (issue_rs1 != '0) && (cnt_rs1 != '0)
              && !((cnt_rs1 == CNT_ONE) && wb_ret1);
        hz2 = issue_re2 && (issue_rs2 != '0) && (cnt_rs2 != '0)
              && !((cnt_rs2 == CNT_ONE) && wb_ret2);
        ov  = issue_we && (issue_rd != '0) && (cnt_rd == CNT_MAX) && !wb_retd;

        stall     = issue_valid && !flush && (hz1 || hz2 || ov);
        acc       = issue_valid && !stall && !flush;
        inc       = acc && issue_we && (issue_rd != '0);
        dec       = wb_nz && (cnt_wb != '0);
        underflow = wb_nz && (cnt_wb == '0) && !flush;
    end

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i != 0 && !flush) begin
                if (inc && (issue_rd == ADDR_W'(i)) && !(dec && (wb_addr == ADDR_W'(i))))
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                else if (dec && (wb_addr == ADDR_W'(i)) && !(inc && (issue_rd == ADDR_W'(i))))
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
            if (i == 0 || flush)
                cnt_d[i] = '0;
        end

        total_d = total_q;
        if (flush)
            total_d = '0;
        else if (inc && !dec)
            total_d = total_q + TOT_W'(1);
        else if (dec && !inc)
            total_d = total_q - TOT_W'(1);

        err_d = err_q || underflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= cnt_d[i];
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) busy_vec[i] = (cnt_q[i] != '0);
    end

    assign pending_total = total_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized model-checked bench for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        iv, iwe, ire1, ire2;
    logic [4:0]  ird, irs1, irs2;
    logic        wbwe;
    logic [4:0]  wba;
    logic        stall;
    logic [31:0] busy_vec;
    logic [6:0]  pending_total;
    logic        err_underflow;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    bit last_stall;

    int m_cnt [32];
    bit m_err;

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(iv), .issue_we(iwe), .issue_rd(ird),
        .issue_re1(ire1), .issue_rs1(irs1), .issue_re2(ire2), .issue_rs2(irs2),
        .wb_we(wbwe), .wb_addr(wba),
        .stall(stall), .busy_vec(busy_vec), .pending_total(pending_total),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = (m_cnt[i] > 0);
        return v;
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < 32; i++) s += m_cnt[i];
        return s;
    endfunction

    function automatic bit retiring(int r);
        return wbwe && (int'(wba) == r) && r != 0;
    endfunction

    function automatic bit src_waits(int r, bit re);
        return re && r != 0 && m_cnt[r] > 0 && !(m_cnt[r] == 1 && retiring(r));
    endfunction

    function automatic bit m_stall();
        bit full = iwe && ird != 0 && m_cnt[ird] == 3 && !retiring(int'(ird));
        return iv && !flush && (src_waits(int'(irs1), ire1) || src_waits(int'(irs2), ire2) || full);
    endfunction

    task automatic cycle();
        int pre;
        bit s;
        @(negedge clk);
        s = m_stall();
        last_stall = stall;
        if (chk_en) begin
            check("stall", {31'd0, stall}, {31'd0, s});
            check("busy", busy_vec, m_busy());
            check("total", {25'd0, pending_total}, m_total());
            check("err", {31'd0, err_underflow}, {31'd0, m_err});
        end
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_err = 1'b0;
        end else if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            pre = m_cnt[wba];
            if (iv && !s && iwe && ird != 0) m_cnt[ird]++;
            if (wbwe && wba != 0) begin
                if (pre > 0) m_cnt[wba]--;
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; iv = 0; iwe = 0; ird = 0;
        ire1 = 0; irs1 = 0; ire2 = 0; irs2 = 0; wbwe = 0; wba = 0;
    endtask

    task automatic issue_w(input logic [4:0] rd);
        idle(); iv = 1; iwe = 1; ird = rd;
    endtask

    task automatic wb(input logic [4:0] a);
        idle(); wbwe = 1; wba = a;
    endtask

    initial begin
        idle();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0;

        // reset held two cycles while ID pushes a write
        issue_w(5'd5); rst = 1;
        cycle(); cycle();
        idle(); chk_en = 1;
        check("rst_busy", busy_vec, 32'd0);
        check("rst_total", {25'd0, pending_total}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_err", {31'd0, err_underflow}, 32'd0);

        // RAW stall and release
        issue_w(5'd3); cycle();
        check("raw_busy", busy_vec, 32'h8);
        idle(); iv = 1; ire1 = 1; irs1 = 3;
        cycle(); check("raw_stall", {31'd0, last_stall}, 32'd1);
        cycle(); check("raw_hold", {31'd0, last_stall}, 32'd1);
        wbwe = 1; wba = 3;
        cycle(); check("raw_fwd", {31'd0, last_stall}, 32'd0);
        idle(); check("raw_clear", busy_vec, 32'd0);

        // overflow on a fourth in-flight write
        issue_w(5'd7); cycle(); cycle(); cycle();
        check("ov_total", {25'd0, pending_total}, 32'd3);
        cycle(); check("ov_stall", {31'd0, last_stall}, 32'd1);
        wbwe = 1; wba = 7;
        cycle(); check("ov_fwd", {31'd0, last_stall}, 32'd0);
        check("ov_keep", {25'd0, pending_total}, 32'd3);
        wb(5'd7); cycle(); cycle(); cycle();

        // x0 and simultaneous inc/dec
        issue_w(5'd0); ire1 = 1; irs1 = 0;
        cycle(); check("x0_stall", {31'd0, last_stall}, 32'd0);
        check("x0_total", {25'd0, pending_total}, 32'd0);
        issue_w(5'd9); cycle();
        issue_w(5'd9); wbwe = 1; wba = 9; cycle();
        check("sim_total", {25'd0, pending_total}, 32'd1);
        check("sim_busy", busy_vec, 32'h200);
        wb(5'd9); cycle();

        // underflow is sticky
        wb(5'd12); cycle();
        idle(); check("uf_set", {31'd0, err_underflow}, 32'd1);
        cycle(); check("uf_sticky", {31'd0, err_underflow}, 32'd1);

        // flush with a would-be stalling issue
        issue_w(5'd4); cycle(); cycle();
        issue_w(5'd8); cycle();
        idle(); flush = 1; iv = 1; ire1 = 1; irs1 = 4; wbwe = 1; wba = 20;
        cycle(); check("fl_stall", {31'd0, last_stall}, 32'd0);
        idle();
        check("fl_busy", busy_vec, 32'd0);
        check("fl_total", {25'd0, pending_total}, 32'd0);

        // reset mid-operation
        for (int r = 1; r <= 5; r++) begin issue_w(5'(r)); cycle(); end
        idle(); check("mid_total", {25'd0, pending_total}, 32'd5);
        rst = 1; cycle(); idle();
        check("mid_busy", busy_vec, 32'd0);
        check("mid_total0", {25'd0, pending_total}, 32'd0);
        check("mid_err", {31'd0, err_underflow}, 32'd0);

        // randomized traffic on a few registers to force collisions
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            iv    = ($urandom_range(0, 3) != 0);
            iwe   = $urandom_range(0, 1);
            ird   = 5'($urandom_range(0, 7));
            ire1  = $urandom_range(0, 1);
            irs1  = 5'($urandom_range(0, 7));
            ire2  = $urandom_range(0, 1);
            irs2  = 5'($urandom_range(0, 7));
            wbwe  = ($urandom_range(0, 2) != 0);
            wba   = 5'($urandom_range(0, 7));
            for (int t = 0; t < 6; t++) begin
                if (m_cnt[wba] == 0 && $urandom_range(0, 9) != 0) wba = 5'($urandom_range(1, 7));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
